// File: rtl/wb_stage.sv
// Write-back stage: registers the memory-stage bus, selects the write-back value,
// drives the register-file port and commit interface, counts retirements and halts on ebreak.
module wb_stage #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned PC_WIDTH       = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned WB_SEL_WIDTH   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [2*PC_WIDTH+3*DATA_WIDTH+REG_ADDR_WIDTH+WB_SEL_WIDTH+2-1:0] mem_wb_bus,
  input  logic                      s_valid,
  output logic                      s_ready,
  output logic                      rf_wen,
  output logic [REG_ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0]     rf_wdata,
  output logic                      mem_wb_reg_wen,
  output logic [REG_ADDR_WIDTH-1:0] mem_wb_reg_waddr,
  output logic [DATA_WIDTH-1:0]     mem_wb_reg_wdata,
  output logic                      commit_valid,
  output logic [PC_WIDTH-1:0]       commit_pc,
  output logic [DATA_WIDTH-1:0]     commit_instr,
  output logic [PC_WIDTH-1:0]       commit_next_pc,
  output logic [63:0]               instret,
  output logic                      halted
);

  typedef struct packed {
    logic [PC_WIDTH-1:0]       pc;
    logic [DATA_WIDTH-1:0]     instr;
    logic [PC_WIDTH-1:0]       pc_4;
    logic                      reg_wen;
    logic [WB_SEL_WIDTH-1:0]   wb_sel;
    logic [REG_ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0]     alu_out;
    logic [DATA_WIDTH-1:0]     mem_out;
    logic                      branch_taken;
  } mem_wb_t;

  typedef enum logic [0:0] {StRun, StHalt} state_e;

  localparam logic [DATA_WIDTH-1:0] EbreakInstr = DATA_WIDTH'(32'h0010_0073);

  mem_wb_t             mem_wb_reg_q, mem_wb_reg_d;
  mem_wb_t             bus_in;
  logic                pipe_is_valid_q, pipe_is_valid_d;
  logic [63:0]         instret_q, instret_d;
  state_e              state_q, state_d;
  logic                ready_go;
  logic                valid_eff;
  logic                is_ebreak;
  logic [DATA_WIDTH-1:0] wb_data;

  assign bus_in   = mem_wb_t'(mem_wb_bus);
  assign ready_go = 1'b1;
  assign halted   = (state_q == StHalt);
  assign s_ready  = ~halted;

  // An instruction accepted alongside a retiring ebreak is squashed by the halt.
  assign valid_eff = pipe_is_valid_q & ready_go & ~halted;
  assign is_ebreak = (mem_wb_reg_q.instr == EbreakInstr);

  always_comb begin
    wb_data = '0;
    case (mem_wb_reg_q.wb_sel)
      WB_SEL_WIDTH'(0): wb_data = mem_wb_reg_q.alu_out;
      WB_SEL_WIDTH'(1): wb_data = mem_wb_reg_q.mem_out;
      WB_SEL_WIDTH'(2): wb_data = DATA_WIDTH'(mem_wb_reg_q.pc_4);
      default:          wb_data = '0;
    endcase
  end

  always_comb begin
    rf_wen   = valid_eff & mem_wb_reg_q.reg_wen & (mem_wb_reg_q.waddr != '0);
    rf_waddr = valid_eff ? mem_wb_reg_q.waddr : '0;
    rf_wdata = valid_eff ? wb_data : '0;

    mem_wb_reg_wen   = rf_wen;
    mem_wb_reg_waddr = rf_waddr;
    mem_wb_reg_wdata = rf_wdata;

    commit_valid   = valid_eff;
    commit_pc      = valid_eff ? mem_wb_reg_q.pc : '0;
    commit_instr   = valid_eff ? mem_wb_reg_q.instr : '0;
    commit_next_pc = mem_wb_reg_q.branch_taken ? PC_WIDTH'(mem_wb_reg_q.alu_out)
                                               : mem_wb_reg_q.pc_4;
    instret        = instret_q;
  end

  always_comb begin
    pipe_is_valid_d = pipe_is_valid_q;
    mem_wb_reg_d    = mem_wb_reg_q;
    instret_d       = instret_q;
    if (s_ready) begin
      pipe_is_valid_d = s_valid;
      if (s_valid) begin
        mem_wb_reg_d = bus_in;
      end
    end else begin
      pipe_is_valid_d = 1'b0;
    end
    if (valid_eff) begin
      instret_d = instret_q + 64'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:   if (valid_eff && is_ebreak) state_d = StHalt;
      StHalt:  state_d = StHalt;
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_wb_reg_q    <= '0;
      pipe_is_valid_q <= 1'b0;
      instret_q       <= '0;
      state_q         <= StRun;
    end else begin
      mem_wb_reg_q    <= mem_wb_reg_d;
      pipe_is_valid_q <= pipe_is_valid_d;
      instret_q       <= instret_d;
      state_q         <= state_d;
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: directed words push hand-computed commits into a queue
// that a negedge monitor pops whenever the stage retires an instruction.
module tb_wb_stage;

  localparam int unsigned BusW = 169;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] next_pc;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [63:0] instret;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [BusW-1:0] mem_wb_bus;
  logic            s_valid;
  logic            s_ready;
  logic            rf_wen;
  logic [4:0]      rf_waddr;
  logic [31:0]     rf_wdata;
  logic            mem_wb_reg_wen;
  logic [4:0]      mem_wb_reg_waddr;
  logic [31:0]     mem_wb_reg_wdata;
  logic            commit_valid;
  logic [31:0]     commit_pc;
  logic [31:0]     commit_instr;
  logic [31:0]     commit_next_pc;
  logic [63:0]     instret;
  logic            halted;

  int   n_checks = 0;
  int   n_fails  = 0;
  exp_t exp_q[$];
  logic [63:0] exp_count = 0;

  wb_stage dut (
    .clk              (clk),
    .rst              (rst),
    .mem_wb_bus       (mem_wb_bus),
    .s_valid          (s_valid),
    .s_ready          (s_ready),
    .rf_wen           (rf_wen),
    .rf_waddr         (rf_waddr),
    .rf_wdata         (rf_wdata),
    .mem_wb_reg_wen   (mem_wb_reg_wen),
    .mem_wb_reg_waddr (mem_wb_reg_waddr),
    .mem_wb_reg_wdata (mem_wb_reg_wdata),
    .commit_valid     (commit_valid),
    .commit_pc        (commit_pc),
    .commit_instr     (commit_instr),
    .commit_next_pc   (commit_next_pc),
    .instret          (instret),
    .halted           (halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [BusW-1:0] mk(input logic [31:0] pc, input logic [31:0] instr,
                                         input logic [31:0] pc4, input logic wen,
                                         input logic [1:0] sel, input logic [4:0] waddr,
                                         input logic [31:0] alu, input logic [31:0] mem,
                                         input logic bt);
    return {pc, instr, pc4, wen, sel, waddr, alu, mem, bt};
  endfunction

  // Offer one word for a single edge; expected commit is queued when e_push is set.
  task automatic send(input logic [BusW-1:0] w, input logic e_push, input logic [31:0] e_pc,
                      input logic [31:0] e_instr, input logic [31:0] e_npc, input logic e_wen,
                      input logic [4:0] e_waddr, input logic [31:0] e_wdata);
    exp_t e;
    mem_wb_bus = w;
    s_valid    = 1'b1;
    if (e_push) begin
      e.pc = e_pc; e.instr = e_instr; e.next_pc = e_npc; e.wen = e_wen;
      e.waddr = e_waddr; e.wdata = e_wdata; e.instret = exp_count;
      exp_q.push_back(e);
      exp_count++;
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (commit_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fails++;
        $display("FAIL unexpected_commit: got pc %h, expected no commit", commit_pc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("commit_pc", 64'(commit_pc), 64'(e.pc));
        check("commit_instr", 64'(commit_instr), 64'(e.instr));
        check("commit_next_pc", 64'(commit_next_pc), 64'(e.next_pc));
        check("rf_wen", 64'(rf_wen), 64'(e.wen));
        check("rf_waddr", 64'(rf_waddr), 64'(e.waddr));
        check("rf_wdata", 64'(rf_wdata), 64'(e.wdata));
        check("fwd_wen", 64'(mem_wb_reg_wen), 64'(e.wen));
        check("fwd_waddr", 64'(mem_wb_reg_waddr), 64'(e.waddr));
        check("fwd_wdata", 64'(mem_wb_reg_wdata), 64'(e.wdata));
        check("instret_at_commit", instret, e.instret);
      end
    end
  end

  task automatic check_idle(input string tag, input logic [63:0] e_instret,
                            input logic e_halted);
    check({tag, "_commit_valid"}, 64'(commit_valid), 64'd0);
    check({tag, "_rf_wen"}, 64'(rf_wen), 64'd0);
    check({tag, "_instret"}, instret, e_instret);
    check({tag, "_halted"}, 64'(halted), 64'(e_halted));
    check({tag, "_s_ready"}, 64'(s_ready), 64'(!e_halted));
  endtask

  initial begin
    rst        = 1'b1;
    s_valid    = 1'b0;
    mem_wb_bus = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset then idle
    @(negedge clk);
    check_idle("reset", 64'd0, 1'b0);
    check("reset_rf_waddr", 64'(rf_waddr), 64'd0);
    check("reset_rf_wdata", 64'(rf_wdata), 64'd0);
    check("reset_commit_pc", 64'(commit_pc), 64'd0);
    check("reset_commit_instr", 64'(commit_instr), 64'd0);
    check("reset_commit_next_pc", 64'(commit_next_pc), 64'd0);
    @(posedge clk); #1;

    // ALU, load, JAL back to back
    send(mk(32'h8000_0000, 32'h0010_0093, 32'h8000_0004, 1'b1, 2'd0, 5'd1,
            32'h10, 32'h20, 1'b0),
         1'b1, 32'h8000_0000, 32'h0010_0093, 32'h8000_0004, 1'b1, 5'd1, 32'h10);
    send(mk(32'h8000_0000, 32'h0000_2103, 32'h8000_0004, 1'b1, 2'd1, 5'd2,
            32'h10, 32'h20, 1'b0),
         1'b1, 32'h8000_0000, 32'h0000_2103, 32'h8000_0004, 1'b1, 5'd2, 32'h20);
    send(mk(32'h8000_0000, 32'h0000_01ef, 32'h8000_0004, 1'b1, 2'd2, 5'd3,
            32'h10, 32'h20, 1'b0),
         1'b1, 32'h8000_0000, 32'h0000_01ef, 32'h8000_0004, 1'b1, 5'd3, 32'h8000_0004);
    s_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_idle("gap", 64'd3, 1'b0);
    @(posedge clk); #1;

    // x0 write suppressed; taken and not-taken branch
    send(mk(32'h8000_0010, 32'h0550_0013, 32'h8000_0014, 1'b1, 2'd0, 5'd0,
            32'h55, 32'h0, 1'b0),
         1'b1, 32'h8000_0010, 32'h0550_0013, 32'h8000_0014, 1'b0, 5'd0, 32'h55);
    send(mk(32'h8000_0200, 32'h0020_8063, 32'h8000_0204, 1'b0, 2'd0, 5'd0,
            32'h8000_0100, 32'h0, 1'b1),
         1'b1, 32'h8000_0200, 32'h0020_8063, 32'h8000_0100, 1'b0, 5'd0, 32'h8000_0100);
    send(mk(32'h8000_0200, 32'h0020_8063, 32'h8000_0204, 1'b0, 2'd0, 5'd0,
            32'h8000_0100, 32'h0, 1'b0),
         1'b1, 32'h8000_0200, 32'h0020_8063, 32'h8000_0204, 1'b0, 5'd0, 32'h8000_0100);
    s_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_idle("gap2", 64'd6, 1'b0);
    @(posedge clk); #1;

    // Reset pulsed while a valid word is held
    send(mk(32'h8000_0020, 32'h0070_0193, 32'h8000_0024, 1'b1, 2'd0, 5'd3,
            32'h7, 32'h0, 1'b0),
         1'b1, 32'h8000_0020, 32'h0070_0193, 32'h8000_0024, 1'b1, 5'd3, 32'h7);
    s_valid = 1'b0;
    rst     = 1'b1;
    @(posedge clk); #1;
    rst       = 1'b0;
    exp_count = 0;
    @(negedge clk);
    check_idle("post_rst", 64'd0, 1'b0);
    @(posedge clk); #1;

    // ebreak followed by two more words
    send(mk(32'h8000_0300, 32'h0010_0073, 32'h8000_0304, 1'b0, 2'd0, 5'd0,
            32'h0, 32'h0, 1'b0),
         1'b1, 32'h8000_0300, 32'h0010_0073, 32'h8000_0304, 1'b0, 5'd0, 32'h0);
    mem_wb_bus = mk(32'h8000_0304, 32'h0010_0093, 32'h8000_0308, 1'b1, 2'd0, 5'd1,
                    32'h99, 32'h0, 1'b0);
    @(negedge clk);
    check("ebreak_cycle_s_ready", 64'(s_ready), 64'd1);
    check("ebreak_cycle_halted", 64'(halted), 64'd0);
    @(posedge clk); #1;
    mem_wb_bus = mk(32'h8000_0308, 32'h0010_0113, 32'h8000_030c, 1'b1, 2'd0, 5'd2,
                    32'h77, 32'h0, 1'b0);
    @(negedge clk);
    check_idle("halt1", 64'd1, 1'b1);
    @(posedge clk); #1;
    s_valid = 1'b0;
    @(negedge clk);
    check_idle("halt2", 64'd1, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("halt3", 64'd1, 1'b1);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
# wb_stage

Write-back stage of the five-stage NPC pipeline, directly downstream of the memory stage. It registers the memory-to-write-back bus under a valid/ready handshake and selects the write-back value. It drives the register-file write port, exports forwarding information, retires instructions and counts them. It also detects `ebreak` and halts the pipeline.

## Interface
- `DATA_WIDTH`, 32: register/data width.
- `PC_WIDTH`, 32: PC width.
- `REG_ADDR_WIDTH`, 5: register index width.
- `WB_SEL_WIDTH`, 2: write-back select width.
- `clk`  in  1: single clock; all state updates on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `mem_wb_bus`  in  `2*PC_WIDTH+3*DATA_WIDTH+REG_ADDR_WIDTH+WB_SEL_WIDTH+2` (169 at defaults): MSB→LSB fields are {PC, Instr, PC_4, reg_wen, reg_wb_sel, reg_waddr, alu_out, mem_out, branch_taken}.
- `s_valid`  in  1: memory stage offers a bus word.
- `s_ready`  out  1: this stage accepts.
- `rf_wen`  out  1: register-file write enable.
- `rf_waddr`  out  `REG_ADDR_WIDTH`: write index.
- `rf_wdata`  out  `DATA_WIDTH`: write data.
- `mem_wb_reg_wen`  out  1: forwarding/hazard view of the pending write; same value as `rf_wen`.
- `mem_wb_reg_waddr`  out  `REG_ADDR_WIDTH`: forwarding/hazard view of the write index.
- `mem_wb_reg_wdata`  out  `DATA_WIDTH`: forwarding/hazard view of the write data.
- `commit_valid`  out  1: one instruction retires this cycle.
- `commit_pc`  out  `PC_WIDTH`: PC of the retiring instruction.
- `commit_instr`  out  `DATA_WIDTH`: instruction word of the retiring instruction.
- `commit_next_pc`  out  `PC_WIDTH`: architectural next PC of the retiring instruction.
- `instret`  out  64: retired-instruction counter.
- `halted`  out  1: sticky; an `ebreak` has retired.

## Operation
- Holding register `mem_wb_reg` plus flag `pipe_is_valid`.
- `ready_go` is always 1.
- `s_ready = ~halted`. This stage is the final consumer, so it never back-pressures except when halted.
- `pipe_is_valid` update at each edge when `s_ready` is 1:
  - `pipe_is_valid <= s_valid`.
  - `mem_wb_reg <= mem_wb_bus` only when `s_valid && s_ready`; otherwise the register holds.
- When `halted`, `pipe_is_valid` clears at the next edge and stays 0.
- Write-back select (`wb_data`):
  - 0 → `alu_out`
  - 1 → `mem_out`
  - 2 → `PC_4`
  - 3 → 0 (reserved)
- `rf_wen = pipe_is_valid && reg_wen && (reg_waddr != 0)`. Writes to x0 are suppressed.
- `rf_waddr = pipe_is_valid ? reg_waddr : 0`.
- `rf_wdata = pipe_is_valid ? wb_data : 0`.
- The `mem_wb_reg_*` outputs are identical to the `rf_*` outputs.
- Commit outputs:
  - `commit_valid = pipe_is_valid`.
  - `commit_pc` and `commit_instr` come from the register, gated to 0 when not valid.
  - `commit_next_pc = branch_taken ? alu_out : PC_4`.
- `instret` increments by 1 at each edge where `commit_valid` is 1, and wraps modulo 2^64.
- Halt: at an edge where `pipe_is_valid` is 1 and `Instr == 32'h00100073`, `halted <= 1`.
  - The `ebreak` itself retires and is counted.
  - `halted` is cleared only by `rst`.
- State machine `RUN` → `HALT`:
  - `RUN` → `HALT` on a committed `ebreak`.
  - `HALT` → `RUN` only on `rst`.

## Timing
- Reset values:
  - `mem_wb_reg`, `pipe_is_valid`, `instret`, `halted` all reset to 0.
  - Hence every output is 0 after reset, except `s_ready`, which is 1.
- Latency: a word handed over at edge N (`s_valid && s_ready`) is presented on the `rf_*` and `commit_*` outputs during cycle N+1.
  - The register file samples `rf_*` at edge N+1.
  - `instret` reflects the instruction after edge N+1.
- Throughput: one instruction per cycle with no bubbles.
- A gap in `s_valid` produces exactly one cycle with `commit_valid` = 0 and `rf_wen` = 0.
- Simultaneous events:
  - An `ebreak` committing in cycle N+1 while `s_valid` = 1 is accepted: `s_ready` is still 1 during that cycle.
  - That following instruction becomes valid in cycle N+2, but `halted` = 1 from N+2, so it is dropped at the N+2 edge.
  - Required: that instruction does not commit. Implement `commit_valid`, `rf_wen`, and the `instret` increment each ANDed with `~halted`.
- From the cycle after the `ebreak` commits, `s_ready` = 0.
- `rst` asserted mid-stream: at the next edge all state is zeroed and any in-flight write is discarded. The write is not performed in the reset cycle's successor.
- `rst` has priority over handshake capture and over halt.

## Test plan
- Reset then idle (`s_valid` = 0) → all outputs 0, `s_ready` = 1, `instret` = 0.
- Back-to-back ALU, load, and JAL words with `reg_wb_sel` = 0/1/2, `alu_out` = 0x10, `mem_out` = 0x20, `PC_4` = 0x80000004:
  - `rf_wdata` = 0x10, 0x20, 0x80000004 in consecutive cycles.
  - `instret` = 3.
- Write to x0 with `reg_wen` = 1 → `rf_wen` = 0, `commit_valid` = 1.
- Branch with `branch_taken` = 1, `alu_out` = 0x80000100 → `commit_next_pc` = 0x80000100.
  - The same word with `branch_taken` = 0 → `commit_next_pc` = `PC_4`.
- `ebreak` followed by two more valid words:
  - `ebreak` commits and `instret` increments once.
  - `halted` = 1 and `s_ready` = 0 from the next cycle.
  - No further commits.
- `rst` pulsed one cycle while a valid word is held → `commit_valid` = 0 the following cycle, `instret` = 0, `halted` = 0.
